// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller: FSM states and tohost decode constants.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // A tohost store ends the test only when its LSB is set; the value 1 means pass.
    localparam int TOHOST_PASS     = 1;
    localparam int TOHOST_DONE_BIT = 0;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Test-run controller: holds the core in reset, runs it, and watches the tohost store
// for a pass/fail verdict or a cycle timeout.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              CNT_W       = 32,
    parameter int              RST_CYCLES  = 2,
    parameter int              TIMEOUT     = 100,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 'h0000_0FF0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             retire,
    input  logic             mem_we,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_wdata,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [XLEN-2:0]  fail_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [7:0]       HOLD_LAST = 8'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] hold_cnt;
    logic       launch;
    logic       cnt_clr;
    logic       in_run;
    logic       tohost_hit;
    logic       tmo_hit;

    assign in_run     = (state == ST_RUN);
    assign launch     = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign cnt_clr    = rst || launch;
    assign tohost_hit = in_run && mem_we && (mem_addr == TOHOST_ADDR) &&
                        mem_wdata[TOHOST_DONE_BIT];
    assign tmo_hit    = (cycle_cnt == TMO_LAST);

    // Both counters advance in the final RUN cycle too; leaving RUN freezes them.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .clr (cnt_clr),
        .en  (in_run),
        .q   (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instret_cnt (
        .clk (clk),
        .clr (cnt_clr),
        .en  (in_run && retire),
        .q   (instret_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            core_rst  <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            fail_code <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_HOLD;
                        hold_cnt  <= '0;
                        core_rst  <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        timeout   <= 1'b0;
                        fail_code <= '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_RUN;
                        core_rst <= 1'b0;
                        running  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    // A tohost verdict in the timeout cycle takes precedence.
                    if (tohost_hit) begin
                        state    <= ST_DONE;
                        core_rst <= 1'b1;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        if (mem_wdata == XLEN'(TOHOST_PASS)) begin
                            pass <= 1'b1;
                        end else begin
                            fail_code <= mem_wdata[XLEN-1:1];
                        end
                    end else if (tmo_hit) begin
                        state    <= ST_DONE;
                        core_rst <= 1'b1;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: default instance plus a 4-bit-counter instance.
module tb_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (XLEN 32, CNT_W 32, RST_CYCLES 2, TIMEOUT 100)
    logic        rst, start, retire, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        core_rst, running, done, pass, timeout;
    logic [30:0] fail_code;
    logic [31:0] cycle_cnt, instret_cnt;

    run_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .retire      (retire),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .core_rst    (core_rst),
        .running     (running),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .fail_code   (fail_code),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    // Instance B: 4-bit counters, TIMEOUT 15, single hold cycle
    logic        rst_b, start_b, retire_b, mem_we_b;
    logic [31:0] mem_addr_b, mem_wdata_b;
    logic        core_rst_b, running_b, done_b, pass_b, timeout_b;
    logic [30:0] fail_code_b;
    logic [3:0]  cycle_cnt_b, instret_cnt_b;

    run_ctrl #(.CNT_W(4), .TIMEOUT(15), .RST_CYCLES(1)) u_dut_b (
        .clk         (clk),
        .rst         (rst_b),
        .start       (start_b),
        .retire      (retire_b),
        .mem_we      (mem_we_b),
        .mem_addr    (mem_addr_b),
        .mem_wdata   (mem_wdata_b),
        .core_rst    (core_rst_b),
        .running     (running_b),
        .done        (done_b),
        .pass        (pass_b),
        .timeout     (timeout_b),
        .fail_code   (fail_code_b),
        .cycle_cnt   (cycle_cnt_b),
        .instret_cnt (instret_cnt_b)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
    endtask

    task automatic no_store();
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
    endtask

    // Pulse start and step through the two hold cycles into RUN.
    task automatic launch_a();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; retire = 1'b0;
        no_store();
        rst_b = 1'b1; start_b = 1'b0; retire_b = 1'b0;
        mem_we_b = 1'b0; mem_addr_b = 32'h0; mem_wdata_b = 32'h0;

        tick(3);
        check("rst_core_rst",  core_rst, 1);
        check("rst_running",   running, 0);
        check("rst_done",      done, 0);
        check("rst_pass",      pass, 0);
        check("rst_timeout",   timeout, 0);
        check("rst_fail_code", fail_code, 0);
        check("rst_cycle",     cycle_cnt, 0);
        check("rst_instret",   instret_cnt, 0);
        rst = 1'b0;

        // Start latency: core_rst stays high through both hold cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        check("hold1_core_rst", core_rst, 1);
        tick();
        check("hold2_core_rst", core_rst, 1);
        check("hold2_running",  running, 0);
        tick();
        check("run_core_rst", core_rst, 0);
        check("run_running",  running, 1);
        check("run_cycle0",   cycle_cnt, 0);

        // 10 RUN cycles, 7 retires, two stores that must be ignored
        for (int i = 0; i < 10; i++) begin
            retire = (i < 7);
            if (i == 3)      store(32'hFF0, 32'h6);
            else if (i == 5) store(32'hFF4, 32'h1);
            else             no_store();
            tick();
        end
        retire = 1'b0;
        check("pre_hit_running", running, 1);
        check("pre_hit_cycle",   cycle_cnt, 10);
        check("pre_hit_instret", instret_cnt, 7);
        store(32'hFF0, 32'h1);
        tick();
        no_store();
        check("pass_done",     done, 1);
        check("pass_pass",     pass, 1);
        check("pass_timeout",  timeout, 0);
        check("pass_cycle",    cycle_cnt, 11);
        check("pass_instret",  instret_cnt, 7);
        check("pass_core_rst", core_rst, 1);
        check("pass_running",  running, 0);

        // Activity while in DONE must not disturb anything
        retire = 1'b1;
        store(32'hFF0, 32'h7);
        tick(3);
        retire = 1'b0;
        no_store();
        check("held_cycle",   cycle_cnt, 11);
        check("held_instret", instret_cnt, 7);
        check("held_pass",    pass, 1);
        check("held_fcode",   fail_code, 0);
        check("held_done",    done, 1);

        // Restart from DONE, then a failing verdict 0x7 -> code 3
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_done",    done, 0);
        check("restart_pass",    pass, 0);
        check("restart_cycle",   cycle_cnt, 0);
        check("restart_instret", instret_cnt, 0);
        check("restart_core_rst", core_rst, 1);
        tick(2);
        for (int i = 0; i < 4; i++) begin
            retire = (i == 1) || (i == 2);
            tick();
        end
        retire = 1'b1;
        store(32'hFF0, 32'h7);
        tick();
        retire = 1'b0;
        no_store();
        check("fail_done",    done, 1);
        check("fail_pass",    pass, 0);
        check("fail_timeout", timeout, 0);
        check("fail_code",    fail_code, 3);
        check("fail_cycle",   cycle_cnt, 5);
        check("fail_instret", instret_cnt, 3);

        // Timeout with no tohost hit
        launch_a();
        check("tmo_restart_fcode", fail_code, 0);
        tick(99);
        check("tmo_pre_running", running, 1);
        check("tmo_pre_cycle",   cycle_cnt, 99);
        tick();
        check("tmo_done",    done, 1);
        check("tmo_timeout", timeout, 1);
        check("tmo_pass",    pass, 0);
        check("tmo_cycle",   cycle_cnt, 100);

        // Pass verdict in the timeout cycle wins
        launch_a();
        tick(99);
        store(32'hFF0, 32'h1);
        tick();
        no_store();
        check("race_done",    done, 1);
        check("race_pass",    pass, 1);
        check("race_timeout", timeout, 0);
        check("race_cycle",   cycle_cnt, 100);

        // Reset in the middle of RUN
        launch_a();
        for (int i = 0; i < 40; i++) begin
            retire = i[0];
            tick();
        end
        retire = 1'b0;
        check("mid_cycle",   cycle_cnt, 40);
        check("mid_instret", instret_cnt, 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_core_rst", core_rst, 1);
        check("mid_rst_running",  running, 0);
        check("mid_rst_done",     done, 0);
        check("mid_rst_cycle",    cycle_cnt, 0);
        check("mid_rst_instret",  instret_cnt, 0);

        // Reset beats a simultaneous start: no run should follow
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        tick(4);
        check("rst_prio_running",  running, 0);
        check("rst_prio_core_rst", core_rst, 1);
        check("rst_prio_cycle",    cycle_cnt, 0);

        // Instance B: 4-bit counters with a retire every cycle
        rst_b = 1'b0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("b_hold_core_rst", core_rst_b, 1);
        tick();
        check("b_run_running", running_b, 1);
        retire_b = 1'b1;
        tick(14);
        check("b_pre_cycle",   cycle_cnt_b, 14);
        check("b_pre_running", running_b, 1);
        tick();
        check("b_done",    done_b, 1);
        check("b_timeout", timeout_b, 1);
        check("b_cycle",   cycle_cnt_b, 15);
        check("b_instret", instret_cnt_b, 15);
        tick(5);
        retire_b = 1'b0;
        check("b_hold_instret", instret_cnt_b, 15);
        check("b_hold_cycle",   cycle_cnt_b, 15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
